// File: rtl/bram_stream_reader_pkg.sv
// Shared types and constants for the block-RAM stream reader.
//   state_t    : reader FSM states (IDLE, RUN, DRAIN)
//   SKID_DEPTH : entries in the output skid buffer
//   SKID_CNT_W : width of the skid buffer occupancy count
package bram_stream_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  localparam int SKID_DEPTH = 2;
  localparam int SKID_CNT_W = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/bram_stream_reader_if.sv
// RAM read-port and output-stream signals of the block-RAM stream reader.
//   mem_read_enable / mem_addr_read : reader -> RAM read port
//   mem_data_out                    : RAM -> reader (registered read data)
//   out_valid / out_data / out_last : reader -> consumer stream
//   out_ready                       : consumer -> reader
// master = reader side, slave = RAM + consumer side.
interface bram_stream_reader_if #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 8
);

  logic                  mem_read_enable;
  logic [ADDR_WIDTH-1:0] mem_addr_read;
  logic [WIDTH-1:0]      mem_data_out;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic                  out_last;

  modport master (
    output mem_read_enable, mem_addr_read, out_valid, out_data, out_last,
    input  mem_data_out, out_ready
  );

  modport slave (
    input  mem_read_enable, mem_addr_read, out_valid, out_data, out_last,
    output mem_data_out, out_ready
  );

endinterface

// File: rtl/bram_stream_reader_skid.sv
// Two-entry skid buffer with valid/ready on both sides.
//   i_clk, i_rst_n           : clock, asynchronous active-low reset
//   i_in_valid/o_in_ready    : upstream handshake, i_in_data payload
//   o_out_valid/i_out_ready  : downstream handshake, o_out_data payload
//   o_count                  : entries currently held (0..2)
// Output payload is held stable while stalled. A push and a pop in the same
// cycle are both taken, so a full buffer still accepts when it is being drained.
module stream_skid_buffer
  import bram_stream_pkg::*;
#(
  parameter int WIDTH = 9
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [WIDTH-1:0]      i_in_data,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [WIDTH-1:0]      o_out_data,
  output logic [SKID_CNT_W-1:0] o_count
);

  logic [WIDTH-1:0]      r_head;
  logic [WIDTH-1:0]      r_skid;
  logic [SKID_CNT_W-1:0] r_cnt;
  logic                  w_push;
  logic                  w_pop;

  assign o_out_valid = (r_cnt != '0);
  assign o_out_data  = r_head;
  assign o_count     = r_cnt;
  assign o_in_ready  = (r_cnt != SKID_CNT_W'(SKID_DEPTH)) | i_out_ready;
  assign w_push      = i_in_valid & o_in_ready;
  assign w_pop       = o_out_valid & i_out_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_head <= '0;
      r_skid <= '0;
      r_cnt  <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_cnt == '0) r_head <= i_in_data;
          else             r_skid <= i_in_data;
          r_cnt <= r_cnt + 1'b1;
        end
        2'b01: begin
          r_head <= r_skid;
          r_cnt  <= r_cnt - 1'b1;
        end
        2'b11: begin
          if (r_cnt == SKID_CNT_W'(1)) begin
            r_head <= i_in_data;
          end else begin
            r_head <= r_skid;
            r_skid <= i_in_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/bram_stream_reader.sv
// Read-side client for the simple-dual-port block RAM: streams count words
// starting at base_addr out as a valid/ready stream, one word per clock.
//   clock, reset_n        : clock, asynchronous active-low reset
//   start/base_addr/count : transfer request (sampled only when idle)
//   busy, done            : transfer in progress / 1-cycle end pulse
//   bus (master)          : RAM read port and output stream
module bram_stream_reader
  import bram_stream_pkg::*;
#(
  parameter  int WIDTH      = 8,
  parameter  int DEPTH      = 256,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   count,
  output logic                  busy,
  output logic                  done,
  bram_stream_reader_if.master  bus
);

  state_t                r_state;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_ren;
  logic                  r_ren_last;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_next_addr;
  logic [ADDR_WIDTH:0]   r_remaining;
  logic                  r_rv;
  logic                  r_rv_last;

  logic [ADDR_WIDTH:0]   w_count_clamped;
  logic [SKID_CNT_W-1:0] w_buf_cnt;
  logic [2:0]            w_outstanding;
  logic                  w_in_ready;
  logic                  w_capture;
  logic                  w_pop;
  logic                  w_issue;
  logic                  w_out_valid;
  logic                  w_out_last;
  logic [WIDTH-1:0]      w_out_data;

  // Credit: every word committed (buffered, parked in the RAM output register,
  // or being read this cycle) must fit in the 2 buffer entries plus the RAM
  // output register. The RAM only updates data_out on read_enable, so an
  // uncaptured word waits there safely while no new read is issued.
  always_comb begin
    w_count_clamped = (count > (ADDR_WIDTH+1)'(DEPTH)) ? (ADDR_WIDTH+1)'(DEPTH) : count;
    w_pop           = w_out_valid & bus.out_ready;
    w_capture       = r_rv & w_in_ready;
    w_outstanding   = 3'(w_buf_cnt) + 3'(r_rv) + 3'(r_ren);
    w_issue         = (r_state == RUN) && (w_outstanding < (3'd3 + 3'(w_pop)));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ren       <= 1'b0;
      r_ren_last  <= 1'b0;
      r_addr      <= '0;
      r_next_addr <= '0;
      r_remaining <= '0;
    end else begin
      r_done <= 1'b0;
      r_ren  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (w_count_clamped == '0) begin
              r_done <= 1'b1;
            end else begin
              // First read goes out on the start edge; the pipeline is empty here.
              r_ren       <= 1'b1;
              r_addr      <= base_addr;
              r_ren_last  <= (w_count_clamped == (ADDR_WIDTH+1)'(1));
              r_next_addr <= base_addr + 1'b1;
              r_remaining <= w_count_clamped - 1'b1;
              r_busy      <= 1'b1;
              r_state     <= (w_count_clamped == (ADDR_WIDTH+1)'(1)) ? DRAIN : RUN;
            end
          end
        end
        RUN: begin
          if (w_issue) begin
            r_ren       <= 1'b1;
            r_addr      <= r_next_addr;
            r_ren_last  <= (r_remaining == (ADDR_WIDTH+1)'(1));
            r_next_addr <= r_next_addr + 1'b1;
            r_remaining <= r_remaining - 1'b1;
            if (r_remaining == (ADDR_WIDTH+1)'(1)) r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_pop && w_out_last) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Tracks whether the RAM output register holds a word not yet captured.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rv      <= 1'b0;
      r_rv_last <= 1'b0;
    end else begin
      r_rv <= r_ren | (r_rv & ~w_capture);
      if (r_ren) r_rv_last <= r_ren_last;
    end
  end

  stream_skid_buffer #(
    .WIDTH(WIDTH + 1)
  ) u_skid (
    .i_clk       (clock),
    .i_rst_n     (reset_n),
    .i_in_valid  (r_rv),
    .o_in_ready  (w_in_ready),
    .i_in_data   ({r_rv_last, bus.mem_data_out}),
    .o_out_valid (w_out_valid),
    .i_out_ready (bus.out_ready),
    .o_out_data  ({w_out_last, w_out_data}),
    .o_count     (w_buf_cnt)
  );

  assign busy                = r_busy;
  assign done                = r_done;
  assign bus.mem_read_enable = r_ren;
  assign bus.mem_addr_read   = r_addr;
  assign bus.out_valid       = w_out_valid;
  assign bus.out_data        = w_out_data;
  assign bus.out_last        = w_out_last;

endmodule
